filte: RTL and testbench

// - Long-term quantizer scale-factor filter (G.726-style FILTE). Updates the slow scale factor YL toward
//   the unlimited scale factor YUP with a 2^-6 leak: YLP = YL + (YUP - YL/64).
// - Pure datapath leaf in the adaptation loop; YLP is fed back as next YL through the caller's delay element.

---
 rtl/filte_pkg.sv | 13 +
 rtl/filte_if.sv | 21 ++
 rtl/filte_dif.sv | 28 ++
 rtl/filte.sv | 48 ++++
 tb/tb_filte.sv | 126 ++++++++++++
 5 files changed

// File: rtl/filte_pkg.sv
// Shared widths and constants for the FILTE long-term scale-factor filter.
// Optional output register is enabled by defining FILTE_OUTREG_EN.
package filte_pkg;

  localparam int YUP_W = 13;
  localparam int YL_W  = 19;
  localparam int DIF_W = 14;

  localparam logic [20:0]     FILTE_BIAS = 21'h100000;
  localparam logic [YL_W-1:0] FILTE_SEXT = 19'h7C000;
  localparam logic [YL_W-1:0] YL_MASK    = 19'h7FFFF;

endpackage

// File: rtl/filte_if.sv
// Signal bundle for the FILTE datapath: scale-factor inputs and update.
// Optional output register is enabled by defining FILTE_OUTREG_EN.
interface filte_if;

  logic [filte_pkg::YUP_W-1:0] yup;
  logic [filte_pkg::YL_W-1:0]  yl;
  logic [filte_pkg::YL_W-1:0]  ylp;

  modport master (
    output yup,
    output yl,
    input  ylp
  );

  modport slave (
    input  yup,
    input  yl,
    output ylp
  );

endinterface

// File: rtl/filte_dif.sv
// FILTE difference path: DIF = YUP - ceil(YL/64) mod 2^14, sign-extended.
// Optional output register is enabled by defining FILTE_OUTREG_EN.
module filte_dif
  import filte_pkg::*;
(
  input  logic [YUP_W-1:0] yup_i,
  input  logic [YL_W-1:0]  yl_i,
  output logic [DIF_W-1:0] dif_o,
  output logic             difs_o,
  output logic [YL_W-1:0]  difsx_o
);

  logic [20:0]      t;
  logic [6:0]       unused_t;
  logic [DIF_W-1:0] dif;

  // Logical shift of the biased value; low YL bits round the step up.
  assign t        = (FILTE_BIAS - {2'b00, yl_i}) >> 6;
  assign unused_t = t[20:14];

  assign dif = DIF_W'({1'b0, yup_i}) + t[DIF_W-1:0];

  assign dif_o   = dif;
  assign difs_o  = dif[DIF_W-1];
  assign difsx_o = dif[DIF_W-1] ? (YL_W'(dif) + FILTE_SEXT)
                                : YL_W'(dif);

endmodule

// File: rtl/filte.sv
// FILTE top: YLP = YL + (YUP - YL/64), wrapping modulo 2^19.
// Optional output register is enabled by defining FILTE_OUTREG_EN.
module filte
  import filte_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [YUP_W-1:0] YUP,
  input  logic [YL_W-1:0]  YL,
  output logic [YL_W-1:0]  YLP
);

  logic [DIF_W-1:0] unused_dif;
  logic             unused_difs;
  logic [YL_W-1:0]  difsx;
  logic [YL_W-1:0]  ylp_d;

  filte_dif u_dif (
    .yup_i   (YUP),
    .yl_i    (YL),
    .dif_o   (unused_dif),
    .difs_o  (unused_difs),
    .difsx_o (difsx)
  );

  // Carry out of bit 18 is dropped; no clamping at either end.
  assign ylp_d = (YL + difsx) & YL_MASK;

`ifdef FILTE_OUTREG_EN
  logic [YL_W-1:0] ylp_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ylp_q <= '0;
    end else begin
      ylp_q <= ylp_d;
    end
  end

  assign YLP = ylp_q;
`else
  logic unused_clk;

  assign unused_clk = clk ^ reset;
  assign YLP        = ylp_d;
`endif

endmodule

// File: tb/tb_filte.sv
// Scoreboard bench for FILTE: directed corner vectors plus random traffic.
// Registered expectations apply when FILTE_OUTREG_EN is defined.
module tb_filte;

  logic clk;
  logic reset;

  filte_if bus ();

  filte dut (
    .clk   (clk),
    .reset (reset),
    .YUP   (bus.yup),
    .YL    (bus.yl),
    .YLP   (bus.ylp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int    exp;
    string name;
  } exp_t;

  exp_t pend_q[$];
  exp_t exp_q[$];

`ifdef FILTE_OUTREG_EN
  localparam bit REG = 1'b1;
`else
  localparam bit REG = 1'b0;
`endif

  // Reference: step toward YUP by the difference to ceil(YL/64), mod 2^19.
  function automatic int ref_ylp(int yup, int yl);
    int step;
    int d;
    int r;
    step = (yl + 63) / 64;
    d    = yup - step;
    d    = ((d % 16384) + 16384) % 16384;
    if (d >= 8192) d = d - 16384;
    r = (yl + d) % 524288;
    if (r < 0) r = r + 524288;
    return r;
  endfunction

  task automatic drive(input int yup, input int yl,
                       input bit rst, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    bus.yup = 13'(yup);
    bus.yl  = 19'(yl);
    reset   = rst;
    e.name  = nm;
    e.exp   = (REG && rst) ? 0 : ref_ylp(yup, yl);
    if (REG) pend_q.push_back(e);
    else     exp_q.push_back(e);
  endtask

  // Registered build: results become visible after the capturing edge.
  always @(posedge clk) begin
    while (pend_q.size() > 0) exp_q.push_back(pend_q.pop_front());
  end

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (bus.ylp !== 19'(e.exp)) begin
        bad++;
        $display("FAIL %s: got %h want %h", e.name, bus.ylp, 19'(e.exp));
      end
    end
  end

  initial begin
    int n;
    bus.yup = '0;
    bus.yl  = '0;
    reset   = 1'b1;

    drive(13'h0000, 19'h00000, 1'b1, "rst0");
    drive(13'h1000, 19'h12345, 1'b1, "rst1");
    drive(13'h0000, 19'h00000, 1'b0, "zero");
    drive(13'h1000, 19'h00000, 1'b0, "dif_pos");
    drive(13'h0000, 19'h00040, 1'b0, "dif_m1");
    drive(13'h0220, 19'h08800, 1'b0, "steady");
    drive(13'h1FFF, 19'h7FFFF, 1'b0, "wrap_top");
    drive(13'h0000, 19'h7FFFF, 1'b0, "neg_top");
    drive(13'h0000, 19'h00001, 1'b0, "yl_bias");
    drive(13'h1FFF, 19'h00000, 1'b0, "max_up");
    drive(13'h1000, 19'h00000, 1'b0, "vec2_again");
    drive(13'h0AAA, 19'h55555, 1'b1, "mid_rst");
    drive(13'h0AAA, 19'h55555, 1'b0, "post_rst");

    for (int i = 0; i < 10000; i++) begin
      drive($urandom_range(0, 8191), $urandom_range(0, 524287),
            ($urandom_range(0, 63) == 0), "rand");
    end

    n = 0;
    while ((pend_q.size() > 0 || exp_q.size() > 0) && n < 10) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    #1;
    if (pend_q.size() > 0 || exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: pending %0d want 0",
               pend_q.size() + exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
